fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the single-cycle instruction memory. Holds the program counter and drives the memory's 6-bit word address. Registers each returned 32-bit instruction, together with its PC, into an output slot that the decode stage consumes through a valid/ready handshake. Supports branch/jump redirects, stops fetching on EBREAK, and optionally traps misaligned redirect targets.

## Interface
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- ADDR_W, 6, instruction-memory word-address width.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  ADDR_W  word address to instruction memory = pc[ADDR_W+1:2]
- imem_data  in  32  instruction word returned combinationally for imem_addr
- out_valid  out  1  output slot holds an instruction for decode
- out_ready  in  1  decode accepts the slot this cycle
- out_instr  out  32  registered instruction
- out_pc  out  32  byte address of out_instr
- redirect_valid  in  1  load redirect_pc into the PC; flush the slot
- redirect_pc  in  32  redirect target (byte address)
- halted  out  1  EBREAK captured; fetching stopped
- misalign  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- Internal state: 32-bit pc, output slot (out_valid, out_instr, out_pc), halted flag, misalign flag.
- Slot is free when out_valid=0 or out_ready=1.
- Fetch fires when the slot is free, halted=0 and redirect_valid=0. On a fetch:
  - out_instr<=imem_data, out_pc<=pc, out_valid<=1
  - pc<=pc+4, modulo 2^32
  - imem_addr wraps naturally at 2^ADDR_W words
- When the slot is free and no fetch fires, out_valid<=0.
- When the slot is not free, the slot and pc hold.
- Redirect has highest priority, and acts regardless of out_ready:
  - pc<={redirect_pc[31:2],2'b00}
  - out_valid<=0
  - No capture that cycle.
  - Ignored while halted=1.
- EBREAK (32'h0010_0073) captured by a fetch sets halted<=1 in the same edge. The EBREAK is still delivered through the slot. No further fetches occur, and pc stays at the EBREAK address+4.
- Only rst clears halted.
- Redirect coincident with an EBREAK on imem_data: the redirect wins, nothing is captured, and halted stays 0.
- States, with transitions:
  - RUN → HALT on EBREAK capture.
  - RUN → TRAP on a misaligned redirect (only when the macro is defined).
  - HALT and TRAP are left only by reset.

## Timing
- Reset values: pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0, misalign=0, imem_addr=RESET_PC[ADDR_W+1:2].
- All outputs except imem_addr are registered. imem_addr is combinational from pc.
- First out_valid=1 follows the first rising edge after rst deasserts, with out_pc=RESET_PC.
- Throughput: one instruction per cycle while out_ready=1.
- Redirect latency:
  - redirect_valid sampled at edge N → out_valid=0 after N, imem_addr=target.
  - Target instruction becomes valid after edge N+1.
- rst asserted mid-stream takes effect immediately, without waiting for clk. Any in-flight slot is discarded.

## Configuration
- FETCH_MISALIGN_CHK_EN defined:
  - A redirect with redirect_pc[1:0]≠0 is not loaded.
  - misalign<=1 and halted<=1 (TRAP).
  - out_valid<=0 and pc holds.
- FETCH_MISALIGN_CHK_EN undefined:
  - Redirect low bits are silently dropped.
  - The misalign output is tied 0.
  - The TRAP state does not exist.

## Test plan
- Sequential fetch: reset with RESET_PC=0, imem words 0..2 = 32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, out_ready=1.
  - Required response: after edges 1/2/3, out_instr = those words and out_pc=0/4/8; imem_addr steps 0,1,2,3.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1.
  - Required response: out_instr, out_pc and imem_addr hold. Fetching resumes the cycle after out_ready=1, with no instruction lost or duplicated.
- Redirect: redirect_valid=1, redirect_pc=32'h0000_00B4.
  - Required response: next cycle out_valid=0 and imem_addr=6'b101101. The following cycle out_pc=32'h0000_00B4. Redirect with out_ready=0 still flushes.
- Wrap and EBREAK:
  - Wrap: pc=32'h0000_00FC, ADDR_W=6 → next imem_addr=0 and out_pc=32'h0000_0100.
  - EBREAK at word 3 → delivered once and halted=1. After the accept, out_valid=0, imem_addr frozen at 4, and a subsequent redirect is ignored.
- Misalign: redirect_pc=32'h0000_0022.
  - Macro defined → misalign=1, halted=1, pc unchanged.
  - Macro undefined → fetch from 32'h0000_0020, misalign=0.
- Async reset: assert rst between clock edges while out_valid=1.
  - Required response: all outputs return to reset values immediately. Fetch restarts at RESET_PC after deassertion.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction-memory addressing, and a one-entry valid/ready output slot.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              halted,
  output logic              misalign
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic [1:0] {RUN, HALT, TRAP} state_t;
`else
  typedef enum logic {RUN, HALT} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic        slot_free;
  logic [31:0] target_pc;

  assign slot_free = !valid_q || out_ready;
  assign target_pc = redirect_pc & ~32'h3;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    if (redirect_valid && state_q == RUN) begin
      // Redirect flushes the slot even if decode is stalled.
      valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_pc[1:0] != 2'b00) state_d = TRAP;
      else                           pc_d    = target_pc;
`else
      pc_d = target_pc;
`endif
    end else if (slot_free) begin
      if (state_q == RUN) begin
        valid_d = 1'b1;
        instr_d = imem_data;
        opc_d   = pc_q;
        pc_d    = pc_q + 32'd4;
        if (imem_data == EBREAK) state_d = HALT;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      opc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
    end
  end

  assign imem_addr = pc_q[ADDR_W+1:2];
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = opc_q;
  assign halted    = (state_q != RUN);
`ifdef FETCH_MISALIGN_CHK_EN
  assign misalign  = (state_q == TRAP);
`else
  assign misalign  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected (pc, instr) pairs queued at stimulus time, checked on each accept.
module tb_fetch_unit;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        halted;
  logic        misalign;

  logic [31:0] mem [64];
  assign imem_data = mem[imem_addr];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .misalign(misalign)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem[pc[7:2]];
    sb.push_back(e);
  endtask

  // Called at a negedge with inputs set; checks any handshake, then advances one cycle.
  task automatic tick();
    exp_t e;
    if (out_valid && out_ready) begin
      chk("sb_avail", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("accept pc=%h instr=%h", out_pc, out_instr);
        chk("acc_pc", out_pc, e.pc);
        chk("acc_instr", out_instr, e.instr);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_instr"}, out_instr, 32'd0);
    chk({tag, "_pc"}, out_pc, 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_misalign"}, 32'(misalign), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i) * 32'h0000_0111;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    mem[2] = 32'h0020_81B3;

    // Reset and sequential fetch
    @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h10);
    tick();
    chk("seq1_pc", out_pc, 32'h0);
    chk("seq1_instr", out_instr, 32'h0050_0093);
    chk("seq1_addr", 32'(imem_addr), 32'd1);
    tick();
    chk("seq2_addr", 32'(imem_addr), 32'd2);
    tick();
    chk("seq3_pc", out_pc, 32'h8);
    chk("seq3_addr", 32'(imem_addr), 32'd3);

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_pc", out_pc, 32'h8);
      chk("bp_instr", out_instr, 32'h0020_81B3);
      chk("bp_addr", 32'(imem_addr), 32'd3);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_resume_pc", out_pc, 32'hC);
    tick();

    // Redirect with decode ready
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_00B4;
    tick();
    redirect_valid = 1'b0;
    chk("rd_valid", 32'(out_valid), 32'd0);
    chk("rd_addr", 32'(imem_addr), 32'b101101);
    push(32'hB4);
    tick();
    chk("rd_tgt_pc", out_pc, 32'hB4);
    tick();

    // Redirect while stalled flushes the slot
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_00F8;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    chk("rdst_valid", 32'(out_valid), 32'd0);
    chk("rdst_addr", 32'(imem_addr), 32'd62);

    // Address wrap
    push(32'hF8); push(32'hFC);
    tick();
    tick();
    chk("wrap_addr", 32'(imem_addr), 32'd0);
    tick();
    chk("wrap_pc", out_pc, 32'h100);
    chk("wrap_instr", out_instr, 32'h0050_0093);

    // Asynchronous reset mid-cycle with a valid slot
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_vals("arst");
    @(negedge clk);
    rst = 1'b0;
    push(32'h0); push(32'h4);
    tick();
    chk("ar_restart_pc", out_pc, 32'h0);
    tick();

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0022;
    tick();
    redirect_valid = 1'b0;
    chk("mis_valid", 32'(out_valid), 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis_flag", 32'(misalign), 32'd1);
    chk("mis_halted", 32'(halted), 32'd1);
    chk("mis_addr", 32'(imem_addr), 32'd2);
    tick();
    chk("mis_hold_valid", 32'(out_valid), 32'd0);
    chk("mis_hold_addr", 32'(imem_addr), 32'd2);
`else
    chk("mis_flag", 32'(misalign), 32'd0);
    chk("mis_halted", 32'(halted), 32'd0);
    chk("mis_addr", 32'(imem_addr), 32'd8);
    push(32'h20);
    tick();
    chk("mis_tgt_pc", out_pc, 32'h20);
    tick();
`endif

    // EBREAK halts fetching
    rst = 1'b1;
    mem[3] = EBREAK;
    @(negedge clk);
    rst = 1'b0;
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    tick();
    tick();
    chk("eb_pre_halted", 32'(halted), 32'd0);
    tick();
    tick();
    chk("eb_halted", 32'(halted), 32'd1);
    chk("eb_instr", out_instr, EBREAK);
    chk("eb_addr", 32'(imem_addr), 32'd4);
    tick();
    chk("eb_after_valid", 32'(out_valid), 32'd0);
    chk("eb_after_addr", 32'(imem_addr), 32'd4);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("eb_frozen_addr", 32'(imem_addr), 32'd4);
      chk("eb_frozen_valid", 32'(out_valid), 32'd0);
      chk("eb_frozen_halted", 32'(halted), 32'd1);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
